// File: rtl/adc_req_sched.sv
// Round-robin scheduler sharing one SAR conversion channel between N_REQ requesters.
// Each grant runs DACEN, SAREN and DACCTL-start writes, waits on busy, then returns DACV.
module adc_req_sched #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned T_TO  = 1023,
  parameter int unsigned T_ACK = 3
) (
  input  logic               clk,
  input  logic               srst,
  input  logic [N_REQ-1:0]   req,
  input  logic [3*N_REQ-1:0] req_ch,
  input  logic               fw_own,
  input  logic [5:0]         cfg_dactl,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [N_REQ-1:0]   err,
  output logic [7:0]         rdat,
  output logic [2:0]         o_wr,
  output logic [7:0]         o_wdat,
  input  logic               i_busy,
  input  logic [63:0]        i_dacv
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CntW = $clog2(T_TO + 1);

  localparam logic [IdxW:0]   NReqW   = (IdxW + 1)'(N_REQ);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_REQ - 1);
  localparam logic [CntW-1:0] AckLim  = CntW'(T_ACK);
  localparam logic [CntW-1:0] ToLim   = CntW'(T_TO);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StCfgEn    = 3'd1;
  localparam logic [2:0] StCfgSar   = 3'd2;
  localparam logic [2:0] StStart    = 3'd3;
  localparam logic [2:0] StWaitAck  = 3'd4;
  localparam logic [2:0] StWaitDone = 3'd5;
  localparam logic [2:0] StStop     = 3'd6;
  localparam logic [2:0] StReport   = 3'd7;

  logic [2:0]       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [N_REQ-1:0] err_q, err_d;
  logic [IdxW-1:0]  owner_q, owner_d;
  logic [IdxW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [2:0]       ch_q, ch_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [7:0]       rdat_q, rdat_d;

  logic             win_found;
  logic [IdxW-1:0]  win_idx;
  logic [N_REQ-1:0] win_oh;
  logic [IdxW:0]    scan;
  logic [CntW-1:0]  cnt_inc;
  logic [IdxW-1:0]  next_ptr;

  // First asserted request at or after rr_ptr, wrapping upward.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_oh    = '0;
    scan      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan = {1'b0, rr_ptr_q} + (IdxW + 1)'(k);
      if (scan >= NReqW) begin
        scan = scan - NReqW;
      end
      if (!win_found && req[scan[IdxW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan[IdxW-1:0];
      end
    end
    win_oh[win_idx] = 1'b1;
  end

  assign cnt_inc  = (cnt_q == ToLim) ? cnt_q : cnt_q + 1'b1;
  assign next_ptr = (owner_q == LastIdx) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    rdat_d   = rdat_q;
    done_d   = '0;
    err_d    = '0;
    unique case (state_q)
      StIdle: begin
        if (!fw_own && !i_busy && win_found) begin
          owner_d = win_idx;
          ch_d    = req_ch[3*int'(win_idx) +: 3];
          gnt_d   = win_oh;
          state_d = StCfgEn;
        end
      end
      StCfgEn:  state_d = StCfgSar;
      StCfgSar: state_d = StStart;
      StStart: begin
        cnt_d   = '0;
        state_d = StWaitAck;
      end
      StWaitAck: begin
        cnt_d = cnt_inc;
        if (i_busy) begin
          state_d = StWaitDone;
        end else if (cnt_inc == AckLim) begin
          state_d = StStop;
          err_d   = gnt_q;
        end
      end
      StWaitDone: begin
        cnt_d = cnt_inc;
        // A falling busy wins over a timeout landing on the same cycle.
        if (!i_busy) begin
          state_d = StReport;
          done_d  = gnt_q;
          rdat_d  = i_dacv[{ch_q, 3'b000} +: 8];
        end else if (cnt_inc == ToLim) begin
          state_d = StStop;
          err_d   = gnt_q;
        end
      end
      StStop, StReport: begin
        state_d  = StIdle;
        gnt_d    = '0;
        rr_ptr_d = next_ptr;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      ch_q     <= '0;
      cnt_q    <= '0;
      rdat_q   <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      rdat_q   <= rdat_d;
    end
  end

  // Mux writes are a pure decode of the current state.
  always_comb begin
    o_wr   = 3'b000;
    o_wdat = 8'h00;
    unique case (state_q)
      StCfgEn: begin
        o_wr   = 3'b010;
        o_wdat = 8'h01 << ch_q;
      end
      StCfgSar: begin
        o_wr   = 3'b100;
        o_wdat = 8'h01 << ch_q;
      end
      StStart: begin
        o_wr   = 3'b001;
        o_wdat = {cfg_dactl, 1'b0, 1'b1};
      end
      StStop: begin
        o_wr   = 3'b001;
        o_wdat = 8'h00;
      end
      default: begin
        o_wr   = 3'b000;
        o_wdat = 8'h00;
      end
    endcase
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign err  = err_q;
  assign rdat = rdat_q;

endmodule

// File: tb/tb_adc_req_sched.sv
// Scoreboard bench for adc_req_sched with a behavioural model of the DAC mux busy flag.
module tb_adc_req_sched;

  localparam int unsigned NReq = 4;
  localparam logic [7:0] StartW = 8'hB5;  // {6'b101101, loop=0, start=1}

  logic              clk = 1'b0;
  logic              srst;
  logic [NReq-1:0]   req;
  logic [3*NReq-1:0] req_ch;
  logic              fw_own;
  logic [5:0]        cfg_dactl;
  logic [NReq-1:0]   gnt, done, err;
  logic [7:0]        rdat;
  logic [2:0]        o_wr;
  logic [7:0]        o_wdat;
  logic              i_busy;
  logic [63:0]       i_dacv;

  adc_req_sched #(
    .N_REQ(NReq),
    .T_TO (1023),
    .T_ACK(3)
  ) dut (
    .clk      (clk),
    .srst     (srst),
    .req      (req),
    .req_ch   (req_ch),
    .fw_own   (fw_own),
    .cfg_dactl(cfg_dactl),
    .gnt      (gnt),
    .done     (done),
    .err      (err),
    .rdat     (rdat),
    .o_wr     (o_wr),
    .o_wdat   (o_wdat),
    .i_busy   (i_busy),
    .i_dacv   (i_dacv)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Mux model: busy rises ack_dly cycles after a start write (0 = never) and
  // falls conv_len cycles later (0 = never); a stop write or reset clears it.
  int   ack_dly  = 2;
  int   conv_len = 120;
  int   since    = 0;
  bit   active   = 1'b0;
  logic mdl_busy = 1'b0;
  logic fw_busy  = 1'b0;
  assign i_busy = mdl_busy | fw_busy;

  always @(negedge clk) begin
    if (srst) begin
      active   = 1'b0;
      mdl_busy = 1'b0;
    end else if (o_wr == 3'b001 && o_wdat[0]) begin
      active = 1'b1;
      since  = 0;
    end else if (o_wr == 3'b001) begin
      active   = 1'b0;
      mdl_busy = 1'b0;
    end else if (active) begin
      since++;
      if (ack_dly != 0 && since == ack_dly) mdl_busy = 1'b1;
      if (ack_dly != 0 && conv_len != 0 && since == ack_dly + conv_len) begin
        mdl_busy = 1'b0;
        active   = 1'b0;
      end
    end
  end

  // Scoreboard: kind 0 = write, 1 = done, 2 = err.
  typedef struct {
    int         kind;
    logic [2:0] wr;
    logic [7:0] wdat;
    logic [3:0] vec;
    logic [7:0] rd;
    int         dly;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   start_cyc = 0;
  exp_t me;
  int   kind_act;

  always @(negedge clk) begin
    if (gnt != '0) begin
      checks++;
      if (!$onehot(gnt)) begin
        errors++;
        $display("FAIL gnt_onehot: got %b want one-hot", gnt);
      end
    end
    if (o_wr != 3'b000) begin
      if (o_wr == 3'b001 && o_wdat[0]) start_cyc = cyc;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL write: got wr=%b wdat=%h want nothing", o_wr, o_wdat);
      end else begin
        me = sbq.pop_front();
        if (me.kind != 0 || me.wr != o_wr || me.wdat != o_wdat) begin
          errors++;
          $display("FAIL write: got wr=%b wdat=%h want kind=%0d wr=%b wdat=%h",
                   o_wr, o_wdat, me.kind, me.wr, me.wdat);
        end
      end
    end
    if ((done | err) != '0) begin
      kind_act = (done != '0) ? 1 : 2;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL pulse: got done=%b err=%b want nothing", done, err);
      end else begin
        me = sbq.pop_front();
        if (me.kind != kind_act || me.vec != (done | err) || gnt != me.vec || rdat != me.rd) begin
          errors++;
          $display("FAIL pulse: got kind=%0d vec=%b gnt=%b rdat=%h want kind=%0d vec=%b rdat=%h",
                   kind_act, done | err, gnt, rdat, me.kind, me.vec, me.rd);
        end
        if (me.dly >= 0) begin
          checks++;
          if (cyc - start_cyc != me.dly) begin
            errors++;
            $display("FAIL latency: got %0d want %0d cycles after start", cyc - start_cyc, me.dly);
          end
        end
      end
    end
  end

  int chs[4] = '{3, 5, 6, 7};
  int rr_order[5] = '{0, 1, 2, 3, 0};
  logic [7:0] rr_rd[5] = '{8'h5A, 8'hC3, 8'h3C, 8'hA7, 8'h5A};

  task automatic push_wr(input logic [2:0] w, input logic [7:0] d);
    exp_t e;
    e.kind = 0; e.wr = w; e.wdat = d; e.vec = '0; e.rd = '0; e.dly = -1;
    sbq.push_back(e);
  endtask

  task automatic push_conv(input int i, input int kind, input logic [7:0] rd, input int dly);
    exp_t e;
    logic [7:0] sel;
    sel = 8'd1 << chs[i];
    push_wr(3'b010, sel);
    push_wr(3'b100, sel);
    push_wr(3'b001, StartW);
    if (kind == 2) push_wr(3'b001, 8'h00);
    e.kind = kind; e.wr = '0; e.wdat = '0; e.vec = 4'd1 << i; e.rd = rd; e.dly = dly;
    sbq.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_pulse(input int maxc, input string tag);
    int n;
    @(negedge clk);
    n = 1;
    while ((done | err) == '0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if ((done | err) == '0) begin
      checks++;
      errors++;
      $display("FAIL %s: got no done/err within %0d cycles want a pulse", tag, maxc);
    end
  endtask

  initial begin
    srst      = 1'b1;
    req       = '0;
    req_ch    = {3'd7, 3'd6, 3'd5, 3'd3};
    fw_own    = 1'b0;
    cfg_dactl = 6'b101101;
    i_dacv    = 64'hA7_3C_C3_11_5A_22_33_44;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rdat", 32'(rdat), 0);
    chk("rst_o_wr", 32'(o_wr), 0);
    chk("rst_o_wdat", 32'(o_wdat), 0);
    srst = 1'b0;

    // Single request on channel 3.
    ack_dly = 2; conv_len = 120;
    push_conv(0, 1, 8'h5A, 123);
    req = 4'b0001;
    wait_pulse(300, "single");
    req = '0;

    // Round-robin from a fresh rr_ptr of 0.
    repeat (2) @(negedge clk);
    srst = 1'b1;
    repeat (2) @(negedge clk);
    srst = 1'b0;
    conv_len = 10;
    foreach (rr_order[g]) push_conv(rr_order[g], 1, rr_rd[g], 13);
    req = 4'b1111;
    repeat (5) wait_pulse(100, "rr");
    req = '0;

    // Timeout: busy stuck high; rdat keeps the last result.
    repeat (2) @(negedge clk);
    conv_len = 0;
    push_conv(2, 2, 8'h5A, 1024);
    req = 4'b0100;
    wait_pulse(1200, "timeout");
    req = '0;

    // No-ack; rr_ptr advanced past 2, so requester 0 beats 2.
    repeat (2) @(negedge clk);
    ack_dly = 0;
    push_conv(0, 2, 8'h5A, 4);
    req = 4'b0101;
    wait_pulse(50, "noack");
    req = '0;

    // fw_own then firmware busy hold off the grant.
    repeat (2) @(negedge clk);
    ack_dly = 2; conv_len = 10;
    fw_own = 1'b1;
    req = 4'b0010;
    repeat (4) begin
      @(negedge clk);
      chk("fw_own_block", 32'(gnt), 0);
    end
    fw_busy = 1'b1;
    fw_own  = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("busy_block", 32'(gnt), 0);
    end
    push_conv(1, 1, 8'hC3, 13);
    fw_busy = 1'b0;
    @(negedge clk);
    chk("grant_unblock", 32'(gnt), 32'h2);
    wait_pulse(100, "unblock");
    req = '0;

    // Reset during WAIT_DONE.
    repeat (2) @(negedge clk);
    conv_len = 0;
    push_wr(3'b010, 8'h08);
    push_wr(3'b100, 8'h08);
    push_wr(3'b001, StartW);
    req = 4'b0001;
    repeat (15) @(negedge clk);
    srst = 1'b1;
    req  = '0;
    @(negedge clk);
    chk("srst_gnt", 32'(gnt), 0);
    chk("srst_o_wr", 32'(o_wr), 0);
    chk("srst_done", 32'(done), 0);
    chk("srst_err", 32'(err), 0);
    @(negedge clk);
    srst = 1'b0;
    conv_len = 10;
    push_conv(1, 1, 8'hC3, 13);
    req = 4'b1010;
    wait_pulse(100, "post_reset");
    req = '0;

    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

endmodule
